// File: rtl/ether_pkg.sv
// Shared types and symbol helpers for the ether_rx receive front end.
`ifndef ETHER_PKG_SV
`define ETHER_PKG_SV

`define ETHER_PARAM_CHECK(label, cond) \
  if (!(cond)) begin : label \
    $error("ether_rx: illegal parameter value"); \
  end

package ether_pkg;

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} ether_state_e;

  function automatic int spb(input int w);
    return 8 / w;
  endfunction

  // Low w bits of the alternating 01 pattern, LSB = 1.
  function automatic logic [7:0] pre_sym(input int w);
    logic [8:0] m;
    m = (9'd1 << w) - 9'd1;
    return 8'h55 & m[7:0];
  endfunction

  function automatic logic [7:0] sfd_sym(input int w);
    return pre_sym(w) | (8'h80 >> (8 - w));
  endfunction

endpackage

`endif

// File: rtl/ether_frame_stats.sv
// Saturating good/bad frame counters fed by single-cycle pulses.
module ether_frame_stats
  import ether_pkg::*;
#(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ok,
  input  logic              i_bad,
  output logic [STAT_W-1:0] o_ok_cnt,
  output logic [STAT_W-1:0] o_bad_cnt
);

  logic [STAT_W-1:0] r_ok_cnt;
  logic [STAT_W-1:0] r_bad_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ok_cnt  <= '0;
      r_bad_cnt <= '0;
    end else begin
      if (i_ok && (r_ok_cnt != '1))
        r_ok_cnt <= r_ok_cnt + 1'b1;
      if (i_bad && (r_bad_cnt != '1))
        r_bad_cnt <= r_bad_cnt + 1'b1;
    end
  end

  assign o_ok_cnt  = r_ok_cnt;
  assign o_bad_cnt = r_bad_cnt;

endmodule

// File: rtl/ether_rx.sv
// Receive front end: strips preamble/SFD, streams payload symbols with a
// one-symbol hold so the final symbol can carry last/error flags.
module ether_rx
  import ether_pkg::*;
#(
  parameter int DATA_W          = 2,
  parameter int MIN_PRE_SYMS    = 31,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int STAT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rxd,
  input  logic              crsdv,
  output logic [DATA_W-1:0] axiod,
  output logic              axiov,
  output logic              axiol,
  output logic              axierr,
  output logic [STAT_W-1:0] frames_ok,
  output logic [STAT_W-1:0] frames_bad
);

  `ETHER_PARAM_CHECK(g_chk_data_w, DATA_W == 2 || DATA_W == 4 || DATA_W == 8)
  `ETHER_PARAM_CHECK(g_chk_min_pre, MIN_PRE_SYMS >= 1 && MIN_PRE_SYMS <= 63)
  `ETHER_PARAM_CHECK(g_chk_max_len, MAX_FRAME_BYTES >= 1)

  localparam int                SPB     = spb(DATA_W);
  localparam int                BC_W    = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [7:0]        PRE8    = pre_sym(DATA_W);
  localparam logic [7:0]        SFD8    = sfd_sym(DATA_W);
  localparam logic [DATA_W-1:0] PRE     = PRE8[DATA_W-1:0];
  localparam logic [DATA_W-1:0] SFD     = SFD8[DATA_W-1:0];
  localparam logic [5:0]        MIN_PRE = 6'(MIN_PRE_SYMS);
  localparam logic [BC_W-1:0]   MAX_B   = BC_W'(MAX_FRAME_BYTES);
  localparam logic [1:0]        PH_LAST = 2'(SPB - 1);

  ether_state_e      r_state;
  logic [5:0]        r_pre_cnt;
  logic [1:0]        r_sym_phase;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_axiod;
  logic              r_axiov;
  logic              r_axiol;
  logic              r_axierr;
  logic              r_ok_pls;
  logic              r_bad_pls;
  logic              w_overlong;

  // A full frame sits exactly on a byte boundary; one more symbol overruns it.
  assign w_overlong = (r_byte_cnt == MAX_B) && (r_sym_phase == 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pre_cnt   <= '0;
      r_sym_phase <= '0;
      r_byte_cnt  <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_axiod     <= '0;
      r_axiov     <= 1'b0;
      r_axiol     <= 1'b0;
      r_axierr    <= 1'b0;
      r_ok_pls    <= 1'b0;
      r_bad_pls   <= 1'b0;
    end else begin
      r_axiov   <= 1'b0;
      r_axiol   <= 1'b0;
      r_axierr  <= 1'b0;
      r_ok_pls  <= 1'b0;
      r_bad_pls <= 1'b0;
      case (r_state)
        IDLE: begin
          if (crsdv) begin
            if (rxd == PRE) begin
              r_state   <= PREAMBLE;
              r_pre_cnt <= 6'd1;
            end else if (rxd != '0) begin
              r_state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!crsdv) begin
            r_state <= IDLE;
          end else if (rxd == PRE) begin
            if (r_pre_cnt != 6'd63)
              r_pre_cnt <= r_pre_cnt + 6'd1;
          end else if ((rxd == SFD) && (r_pre_cnt >= MIN_PRE)) begin
            r_state     <= PAYLOAD;
            r_sym_phase <= '0;
            r_byte_cnt  <= '0;
            r_hold_full <= 1'b0;
          end else begin
            r_state   <= DROP;
            r_bad_pls <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (crsdv && w_overlong) begin
            r_axiod     <= r_hold;
            r_axiov     <= 1'b1;
            r_axiol     <= 1'b1;
            r_axierr    <= 1'b1;
            r_bad_pls   <= 1'b1;
            r_hold_full <= 1'b0;
            r_state     <= DROP;
          end else if (crsdv) begin
            r_hold      <= rxd;
            r_hold_full <= 1'b1;
            if (r_hold_full) begin
              r_axiod <= r_hold;
              r_axiov <= 1'b1;
            end
            if (r_sym_phase == PH_LAST) begin
              r_sym_phase <= '0;
              r_byte_cnt  <= r_byte_cnt + 1'b1;
            end else begin
              r_sym_phase <= r_sym_phase + 2'd1;
            end
          end else begin
            // Carrier dropped: flush the held symbol as last, flag dribble.
            if (r_hold_full) begin
              r_axiod   <= r_hold;
              r_axiov   <= 1'b1;
              r_axiol   <= 1'b1;
              r_axierr  <= (r_sym_phase != 2'd0);
              r_ok_pls  <= (r_sym_phase == 2'd0);
              r_bad_pls <= (r_sym_phase != 2'd0);
            end else begin
              r_bad_pls <= 1'b1;
            end
            r_hold_full <= 1'b0;
            r_state     <= IDLE;
          end
        end
        DROP: begin
          if (!crsdv)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ether_frame_stats #(
    .STAT_W (STAT_W)
  ) u_stats (
    .clk       (clk),
    .rst       (rst),
    .i_ok      (r_ok_pls),
    .i_bad     (r_bad_pls),
    .o_ok_cnt  (frames_ok),
    .o_bad_cnt (frames_bad)
  );

  assign axiod  = r_axiod;
  assign axiov  = r_axiov;
  assign axiol  = r_axiol;
  assign axierr = r_axierr;

endmodule

// File: tb/tb_ether_rx.sv
// Bench for ether_rx: three configurations (2/4/8-bit symbols) driven by
// directed and random frames, checked against a frame-level reference model.
module tb_ether_rx;

  typedef struct {
    int         inst;
    logic [7:0] d;
    logic       v;
    logic       l;
    logic       e;
    int         cyc;
  } beat_t;

  localparam int W_OF   [3] = '{2, 4, 8};
  localparam int MIN_OF [3] = '{31, 15, 7};
  localparam int MAX_OF [3] = '{1522, 1522, 4};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  rxd2 = '0;
  logic [3:0]  rxd4 = '0;
  logic [7:0]  rxd8 = '0;
  logic        dv0 = 1'b0, dv1 = 1'b0, dv2 = 1'b0;
  logic [1:0]  od2;
  logic [3:0]  od4;
  logic [7:0]  od8;
  logic        ov0, ov1, ov2, ol0, ol1, ol2, oe0, oe1, oe2;
  logic [15:0] fo0, fo1, fo2, fb0, fb1, fb2;

  int          cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          exp_ok [3] = '{0, 0, 0};
  int          exp_bad[3] = '{0, 0, 0};
  beat_t       bq[$];
  logic [7:0]  pay[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ether_rx #(.DATA_W(2), .MIN_PRE_SYMS(31), .MAX_FRAME_BYTES(1522), .STAT_W(16)) u_d2 (
    .clk(clk), .rst(rst_n), .rxd(rxd2), .crsdv(dv0), .axiod(od2), .axiov(ov0),
    .axiol(ol0), .axierr(oe0), .frames_ok(fo0), .frames_bad(fb0));
  ether_rx #(.DATA_W(4), .MIN_PRE_SYMS(15), .MAX_FRAME_BYTES(1522), .STAT_W(16)) u_d4 (
    .clk(clk), .rst(rst_n), .rxd(rxd4), .crsdv(dv1), .axiod(od4), .axiov(ov1),
    .axiol(ol1), .axierr(oe1), .frames_ok(fo1), .frames_bad(fb1));
  ether_rx #(.DATA_W(8), .MIN_PRE_SYMS(7), .MAX_FRAME_BYTES(4), .STAT_W(16)) u_d8 (
    .clk(clk), .rst(rst_n), .rxd(rxd8), .crsdv(dv2), .axiod(od8), .axiov(ov2),
    .axiol(ol2), .axierr(oe2), .frames_ok(fo2), .frames_bad(fb2));

  always @(negedge clk) begin
    if (ov0 | ol0 | oe0) bq.push_back('{0, {6'd0, od2}, ov0, ol0, oe0, cyc});
    if (ov1 | ol1 | oe1) bq.push_back('{1, {4'd0, od4}, ov1, ol1, oe1, cyc});
    if (ov2 | ol2 | oe2) bq.push_back('{2, od8, ov2, ol2, oe2, cyc});
  end

  function automatic logic [10:0] out_of(input int k);
    case (k)
      0:       return {6'd0, od2, ov0, ol0, oe0};
      1:       return {4'd0, od4, ov1, ol1, oe1};
      default: return {od8, ov2, ol2, oe2};
    endcase
  endfunction

  function automatic logic [15:0] fo_of(input int k);
    case (k)
      0:       return fo0;
      1:       return fo1;
      default: return fo2;
    endcase
  endfunction

  function automatic logic [15:0] fb_of(input int k);
    case (k)
      0:       return fb0;
      1:       return fb1;
      default: return fb2;
    endcase
  endfunction

  function automatic logic [7:0] mask_of(input int k);
    return 8'((32'd1 << W_OF[k]) - 32'd1);
  endfunction

  function automatic logic [7:0] pre_of(input int k);
    return 8'h55 & mask_of(k);
  endfunction

  function automatic logic [7:0] sfd_of(input int k);
    return pre_of(k) | 8'(32'd1 << (W_OF[k] - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [7:0] sym, input logic v);
    case (k)
      0:       begin rxd2 = sym[1:0]; dv0 = v; end
      1:       begin rxd4 = sym[3:0]; dv1 = v; end
      default: begin rxd8 = sym;      dv2 = v; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int k, input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom) & mask_of(k));
  endtask

  // Drive npre preamble symbols, SFD, the payload in 'pay', then 'gap' idle
  // cycles; compare captured beats and counters with the frame-level model.
  task automatic run_frame(input string nm, input int k, input int npre, input int gap);
    beat_t eb[$];
    int    spb, limit, m, lat0, eff_pre;
    logic  err;
    bq.delete();
    spb = 8 / W_OF[k];
    for (int i = 0; i < npre; i++) send(k, pre_of(k), 1'b1);
    send(k, sfd_of(k), 1'b1);
    lat0 = cyc;
    foreach (pay[i]) send(k, pay[i], 1'b1);
    for (int i = 0; i < gap; i++) send(k, 8'd0, 1'b0);

    eff_pre = (npre > 63) ? 63 : npre;
    if (npre == 0) begin
      // SFD seen from idle is line noise, not a frame: nothing counted.
    end else if (eff_pre < MIN_OF[k] || pay.size() == 0) begin
      exp_bad[k]++;
    end else begin
      limit = MAX_OF[k] * spb;
      m     = (pay.size() > limit) ? limit : pay.size();
      err   = (pay.size() > limit) || ((pay.size() % spb) != 0);
      for (int i = 0; i < m; i++)
        eb.push_back('{k, pay[i], 1'b1, (i == m - 1), (i == m - 1) && err, 0});
      if (err) exp_bad[k]++;
      else     exp_ok[k]++;
    end

    chk({nm, "_beats"}, bq.size(), eb.size());
    for (int i = 0; i < bq.size() && i < eb.size(); i++)
      chk($sformatf("%s_beat%0d", nm, i),
          32'({8'(bq[i].inst), bq[i].d, bq[i].v, bq[i].l, bq[i].e}),
          32'({8'(eb[i].inst), eb[i].d, eb[i].v, eb[i].l, eb[i].e}));
    if (bq.size() > 0 && eb.size() > 0)
      chk({nm, "_latency"}, bq[0].cyc - lat0, 2);
    if (gap >= 3) begin
      chk({nm, "_frames_ok"}, 32'(fo_of(k)), exp_ok[k]);
      chk({nm, "_frames_bad"}, 32'(fb_of(k)), exp_bad[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, npre, npay;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_out%0d", i), 32'(out_of(i)), 32'd0);
      chk($sformatf("reset_ok%0d", i), 32'(fo_of(i)), 32'd0);
      chk($sformatf("reset_bad%0d", i), 32'(fb_of(i)), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean 2-bit frame: two 0xA5 bytes as LSB-first dibits
    pay.delete();
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < 4; s++) pay.push_back((8'hA5 >> (2 * s)) & 8'h03);
    run_frame("clean_d2", 0, 31, 4);

    // Short preamble rejected, then the same frame with full preamble
    fill_random(0, 8);
    run_frame("short_pre", 0, 20, 4);
    fill_random(0, 8);
    run_frame("full_pre", 0, 31, 4);

    // 4-bit frame with an odd nibble count: dribble
    fill_random(1, 5);
    run_frame("dribble_d4", 1, 15, 4);

    // 8-bit frame longer than MAX_FRAME_BYTES=4
    fill_random(2, 6);
    run_frame("overlong_d8", 2, 7, 4);

    // SFD then immediate carrier loss, followed at once by a good frame
    pay.delete();
    run_frame("sfd_only", 0, 31, 1);
    fill_random(0, 12);
    run_frame("after_sfd_only", 0, 31, 4);

    // Reset asserted mid-payload
    for (int i = 0; i < 31; i++) send(0, pre_of(0), 1'b1);
    send(0, sfd_of(0), 1'b1);
    for (int i = 0; i < 4; i++) send(0, 8'($urandom) & mask_of(0), 1'b1);
    chk("midrst_axiov_before", 32'(ov0), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("midrst_out%0d", i), 32'(out_of(i)), 32'd0);
      chk($sformatf("midrst_ok%0d", i), 32'(fo_of(i)), 32'd0);
      chk($sformatf("midrst_bad%0d", i), 32'(fb_of(i)), 32'd0);
      exp_ok[i]  = 0;
      exp_bad[i] = 0;
    end
    dv0  = 1'b0;
    rxd2 = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_random(0, 12);
    run_frame("post_reset", 0, 31, 4);

    // Random frames across all three configurations
    for (int r = 0; r < 30; r++) begin
      k    = int'($urandom_range(0, 2));
      npre = int'($urandom_range(0, 70));
      npay = int'($urandom_range(0, 20));
      fill_random(k, npay);
      run_frame($sformatf("rand%0d", r), k, npre, 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ether_rx.md
Name: ether_rx

Overview:
- Parametrised RMII/MII/GMII-style receive front end: strips preamble and SFD, then streams payload symbols (MAC header through FCS) downstream.
- Generalises the fixed 2-bit RMII stripper in four ways: configurable symbol width, tolerant minimum-preamble length, an end-of-frame marker, and error signalling (dribble, overlong).
- Keeps per-port good/bad frame counters.
- Sits between the PHY pins and the bit-order/FCS-check stage.

Parameters:
- DATA_W, 2, symbol width per clock; legal values 2, 4, 8; SPB = 8/DATA_W symbols per byte.
- MIN_PRE_SYMS, 31, minimum preamble symbols required before SFD; legal range 1..63.
- MAX_FRAME_BYTES, 1522, payload bytes allowed after SFD before the frame is truncated.
- STAT_W, 16, width of frame counters.

Ports:
- clk  in  1  system clock (50 MHz for RMII).
- rst  in  1  asynchronous, active-low reset.
- rxd  in  DATA_W  receive symbol, LSB first on the wire.
- crsdv  in  1  carrier/data valid.
- axiod  out  DATA_W  payload symbol.
- axiov  out  1  axiod valid.
- axiol  out  1  last symbol of frame; only asserted with axiov.
- axierr  out  1  frame error; only asserted with axiol.
- frames_ok  out  STAT_W  count of frames ending cleanly.
- frames_bad  out  STAT_W  count of aborted or errored frames.

Behaviour:
- Symbol constants:
  - PRE = DATA_W bits of the repeating 01 pattern, LSB = 1 (2'b01, 4'h5, 8'h55).
  - SFD_SYM = PRE with MSB set (2'b11, 4'hD, 8'hD5).
- Reset (rst low, asynchronous): state IDLE; axiod=0, axiov=0, axiol=0, axierr=0; counters=0; hold register empty.
- IDLE:
  - crsdv=1 and rxd==PRE: go to PREAMBLE, pre_cnt=1.
  - crsdv=1 and rxd==0: stay in IDLE.
  - crsdv=1 and any other rxd: go to DROP.
- PREAMBLE:
  - crsdv=0: go to IDLE silently; no counter change.
  - rxd==PRE: pre_cnt increments, saturating at 63.
  - rxd==SFD_SYM and pre_cnt>=MIN_PRE_SYMS: go to PAYLOAD; sym_phase=0, byte_cnt=0, hold empty.
  - Anything else: go to DROP and increment frames_bad.
- PAYLOAD, one-symbol hold register so the last symbol can be tagged; latency is 2 clocks from rxd to axiod.
  - crsdv=1:
    - hold is loaded with rxd.
    - If hold was full, the old value is emitted with axiov=1, axiol=0.
    - sym_phase wraps at SPB-1; each wrap increments byte_cnt.
  - crsdv=0 with hold full:
    - Emit hold with axiov=1, axiol=1.
    - axierr=1 iff sym_phase!=0 (dribble).
    - Increment frames_ok or frames_bad accordingly; go to IDLE.
  - crsdv=0 with hold empty (SFD then immediate carrier loss): no output, frames_bad++, go to IDLE.
  - Overlong: a symbol arrives while byte_cnt==MAX_FRAME_BYTES and sym_phase==0.
    - Emit hold with axiol=1, axierr=1; the arriving symbol is discarded.
    - frames_bad++, go to DROP.
- DROP: outputs idle; go to IDLE once crsdv=0.
- Output timing: axiov, axiol and axierr are registered, single-cycle per symbol. axiod holds its last value when axiov=0.
- Counters: saturate at all-ones; they are never cleared except by reset.
- Widths: byte_cnt is $clog2(MAX_FRAME_BYTES+1) bits; pre_cnt is 6 bits.
- Reset mid-frame: everything is cleared immediately. The next frame must begin from IDLE with a fresh preamble.

Decomposition:
- ether_pkg holds:
  - state enum {IDLE, PREAMBLE, PAYLOAD, DROP};
  - functions pre_sym(DATA_W) and sfd_sym(DATA_W);
  - localparam SPB derivation;
  - the legal-parameter assertion macro.
- One sub-module: ether_frame_stats, holding the two saturating STAT_W counters, driven by single-cycle ok/bad pulses.

Test Plan:
- DATA_W=2, 31×01, then 11, then 8 dibits of 0xA5 bytes, then crsdv low.
  - Expect 8 axiov beats, first 2 clocks after the first payload dibit.
  - axiol on beat 8, axierr=0, frames_ok=1.
- DATA_W=2, MIN_PRE_SYMS=31, only 20×01 then 11.
  - Expect no axiov, DROP until crsdv low, frames_bad=1.
  - Repeat the frame with 31×01: accepted.
- DATA_W=4, 15×4'h5, then 4'hD, then 5 nibbles, then crsdv low.
  - Expect 5 beats, axiol with axierr=1 (dribble), frames_bad=1.
- MAX_FRAME_BYTES=4, DATA_W=8, 55×7 then D5, then 6 payload bytes.
  - Expect 4 beats, the 4th with axiol=1 and axierr=1.
  - Bytes 5-6 dropped, frames_bad=1.
- Reset pulsed low mid-PAYLOAD (after 3 beats).
  - Expect axiov=0 asynchronously and counters=0.
  - A following clean frame streams normally.
- SFD followed immediately by crsdv=0: no axiov, frames_bad increments, back to IDLE on the next cycle.
